// File: rtl/clk_pkg.sv
// Shared definitions for the twelve-hour clock family.
//   - state_e       : alarm controller states
//   - HH_MIN/HH_MAX : legal BCD hour range (01..12)
//   - MM_MAX        : largest legal BCD minute (59)
//   - DEF_*         : default timing and snooze parameters
//   - is_bcd()      : true when both nibbles are decimal digits
package clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam logic [7:0] HH_MIN = 8'h01;
  localparam logic [7:0] HH_MAX = 8'h12;
  localparam logic [7:0] MM_MAX = 8'h59;

  localparam int DEF_RING_SECS   = 60;
  localparam int DEF_SNOOZE_SECS = 300;
  localparam int DEF_MAX_SNOOZE  = 3;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_time_valid.sv
// Combinational legality check for a BCD hour/minute pair.
// Ports:
//   i_hh    in  8  hour, BCD (legal 01..12)
//   i_mm    in  8  minute, BCD (legal 00..59)
//   o_valid out 1  both fields legal
module bcd_time_valid
  import clk_pkg::*;
(
  input  logic [7:0] i_hh,
  input  logic [7:0] i_mm,
  output logic       o_valid
);

  logic w_hh_ok;
  logic w_mm_ok;

  // Once both nibbles are decimal digits, plain unsigned comparison of the
  // packed BCD byte orders the same way as the decimal value.
  assign w_hh_ok = is_bcd(i_hh) && (i_hh >= HH_MIN) && (i_hh <= HH_MAX);
  assign w_mm_ok = is_bcd(i_mm) && (i_mm <= MM_MAX);
  assign o_valid = w_hh_ok && w_mm_ok;

endmodule

// File: rtl/twelve_hour_alarm.sv
// Alarm stage fed by the twelve-hour clock. Holds a settable alarm time,
// rings when the live time reaches it, and supports bounded snoozes.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ena                 one-second tick shared with the clock
//   pm, hh, mm, ss      live time (BCD)
//   arm                 level, alarm enabled
//   set_en/set_pm/hh/mm single-cycle strobe loading a new alarm time
//   snooze, stop        single-cycle request strobes
//   alarm_pm/hh/mm      stored alarm time
//   ringing, snoozing   registered state flags
//   snooze_cnt          snoozes used in the current alarm event
//   set_err             one-cycle pulse when a load is rejected
//   dbg_state           current controller state
// All strobes are sampled on the clock edge they are high for; there is no
// backpressure, so a strobe that is not acted on that edge is dropped.
module twelve_hour_alarm
  import clk_pkg::*;
#(
  parameter int RING_SECS   = DEF_RING_SECS,
  parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
  parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ena,
  input  logic                              pm,
  input  logic [7:0]                        hh,
  input  logic [7:0]                        mm,
  input  logic [7:0]                        ss,
  input  logic                              arm,
  input  logic                              set_en,
  input  logic                              set_pm,
  input  logic [7:0]                        set_hh,
  input  logic [7:0]                        set_mm,
  input  logic                              snooze,
  input  logic                              stop,
  output logic                              alarm_pm,
  output logic [7:0]                        alarm_hh,
  output logic [7:0]                        alarm_mm,
  output logic                              ringing,
  output logic                              snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_cnt,
  output logic                              set_err,
  output state_e                            dbg_state
);

  localparam int RT_W  = $clog2(RING_SECS + 1);
  localparam int ST_W  = $clog2(SNOOZE_SECS + 1);
  localparam int CNT_W = $clog2(MAX_SNOOZE + 1);

  localparam logic [RT_W-1:0]  RING_LOAD   = RT_W'(RING_SECS - 1);
  localparam logic [ST_W-1:0]  SNOOZE_LOAD = ST_W'(SNOOZE_SECS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_SNOOZE);

  state_e             r_state, w_state_nxt;
  logic [RT_W-1:0]    r_ring_tmr, w_ring_tmr_nxt;
  logic [ST_W-1:0]    r_snooze_tmr, w_snooze_tmr_nxt;
  logic [CNT_W-1:0]   r_snooze_cnt, w_snooze_cnt_nxt;
  logic               r_alarm_pm;
  logic [7:0]         r_alarm_hh;
  logic [7:0]         r_alarm_mm;
  logic               r_match_q;
  logic               r_ringing;
  logic               r_snoozing;
  logic               r_set_err;

  logic w_set_ok;
  logic w_load;
  logic w_match;
  logic w_trigger;
  logic w_quit;
  logic w_snooze_ok;

  bcd_time_valid u_set_chk (
    .i_hh    (set_hh),
    .i_mm    (set_mm),
    .o_valid (w_set_ok)
  );

  assign w_load      = set_en && w_set_ok;
  assign w_match     = arm && (pm == r_alarm_pm) && (hh == r_alarm_hh) &&
                       (mm == r_alarm_mm) && (ss == 8'h00);
  // Rising edge only: the match holds for a whole second, ring once.
  assign w_trigger   = w_match && !r_match_q;
  assign w_quit      = stop || !arm;
  assign w_snooze_ok = snooze && (r_snooze_cnt < CNT_MAX);

  always_comb begin
    w_state_nxt      = r_state;
    w_ring_tmr_nxt   = r_ring_tmr;
    w_snooze_tmr_nxt = r_snooze_tmr;
    w_snooze_cnt_nxt = r_snooze_cnt;
    if (w_load) begin
      // A fresh alarm time abandons any event in progress, and also
      // suppresses a trigger arriving on the same edge.
      w_state_nxt      = ST_IDLE;
      w_snooze_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            w_state_nxt      = ST_RINGING;
            w_ring_tmr_nxt   = RING_LOAD;
            w_snooze_cnt_nxt = '0;
          end
        end
        ST_RINGING: begin
          if (w_quit) begin
            w_state_nxt      = ST_IDLE;
            w_snooze_cnt_nxt = '0;
          end else if (w_snooze_ok) begin
            w_state_nxt      = ST_SNOOZE;
            w_snooze_tmr_nxt = SNOOZE_LOAD;
            w_snooze_cnt_nxt = r_snooze_cnt + CNT_W'(1);
          end else if (ena) begin
            // An exhausted snooze request falls through to here, so the
            // ring timeout keeps running.
            if (r_ring_tmr == '0) begin
              w_state_nxt      = ST_IDLE;
              w_snooze_cnt_nxt = '0;
            end else begin
              w_ring_tmr_nxt = r_ring_tmr - RT_W'(1);
            end
          end
        end
        ST_SNOOZE: begin
          if (w_quit) begin
            w_state_nxt      = ST_IDLE;
            w_snooze_cnt_nxt = '0;
          end else if (ena) begin
            if (r_snooze_tmr == '0) begin
              w_state_nxt    = ST_RINGING;
              w_ring_tmr_nxt = RING_LOAD;
            end else begin
              w_snooze_tmr_nxt = r_snooze_tmr - ST_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt      = ST_IDLE;
          w_snooze_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ring_tmr   <= '0;
      r_snooze_tmr <= '0;
      r_snooze_cnt <= '0;
      r_alarm_pm   <= 1'b0;
      r_alarm_hh   <= 8'h12;
      r_alarm_mm   <= 8'h00;
      r_match_q    <= 1'b0;
      r_ringing    <= 1'b0;
      r_snoozing   <= 1'b0;
      r_set_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ring_tmr   <= w_ring_tmr_nxt;
      r_snooze_tmr <= w_snooze_tmr_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
      r_match_q    <= w_match;
      r_ringing    <= (w_state_nxt == ST_RINGING);
      r_snoozing   <= (w_state_nxt == ST_SNOOZE);
      r_set_err    <= set_en && !w_set_ok;
      if (w_load) begin
        r_alarm_pm <= set_pm;
        r_alarm_hh <= set_hh;
        r_alarm_mm <= set_mm;
      end
    end
  end

  assign alarm_pm   = r_alarm_pm;
  assign alarm_hh   = r_alarm_hh;
  assign alarm_mm   = r_alarm_mm;
  assign ringing    = r_ringing;
  assign snoozing   = r_snoozing;
  assign snooze_cnt = r_snooze_cnt;
  assign set_err    = r_set_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_twelve_hour_alarm.sv
module tb_twelve_hour_alarm;
  import clk_pkg::*;

  localparam int RING_SECS   = 60;
  localparam int SNOOZE_SECS = 300;
  localparam int MAX_SNOOZE  = 3;
  localparam int CW          = $clog2(MAX_SNOOZE + 1);
  localparam int OW          = 20 + CW;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, ena, pm, arm, set_en, set_pm, snooze, stop;
  logic [7:0] hh, mm, ss, set_hh, set_mm;
  logic alarm_pm, ringing, snoozing, set_err;
  logic [7:0] alarm_hh, alarm_mm;
  logic [CW-1:0] snooze_cnt;
  state_e dbg_state;

  always #5 clk = ~clk;

  twelve_hour_alarm #(
    .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
    .arm(arm), .set_en(set_en), .set_pm(set_pm), .set_hh(set_hh), .set_mm(set_mm),
    .snooze(snooze), .stop(stop), .alarm_pm(alarm_pm), .alarm_hh(alarm_hh),
    .alarm_mm(alarm_mm), .ringing(ringing), .snoozing(snoozing),
    .snooze_cnt(snooze_cnt), .set_err(set_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [OW-1:0] exp_q[$];

  // Reference model: phase + number of ena ticks spent in that phase.
  int         m_mode, m_ticks, m_cnt;
  logic       m_apm, m_err, m_prev;
  logic [7:0] m_ahh, m_amm;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd_to_int(input logic [7:0] v);
    int hi, lo;
    hi = int'(v) / 16;
    lo = int'(v) % 16;
    if (hi > 9 || lo > 9) return -1;
    return hi * 10 + lo;
  endfunction

  function automatic bit time_ok(input logic [7:0] h, input logic [7:0] m);
    int hv, mv;
    hv = bcd_to_int(h);
    mv = bcd_to_int(m);
    return (hv >= 1) && (hv <= 12) && (mv >= 0) && (mv <= 59);
  endfunction

  task automatic model_step();
    bit match, trig;
    if (reset) begin
      m_mode = M_IDLE; m_ticks = 0; m_cnt = 0; m_err = 1'b0; m_prev = 1'b0;
      m_apm = 1'b0; m_ahh = 8'h12; m_amm = 8'h00;
    end else begin
      match  = arm && (pm == m_apm) && (hh == m_ahh) && (mm == m_amm) && (ss == 8'h00);
      trig   = match && !m_prev;
      m_prev = match;
      m_err  = set_en && !time_ok(set_hh, set_mm);
      if (set_en && time_ok(set_hh, set_mm)) begin
        m_apm = set_pm; m_ahh = set_hh; m_amm = set_mm;
        m_mode = M_IDLE; m_cnt = 0;
      end else if (m_mode == M_IDLE) begin
        if (trig) begin m_mode = M_RING; m_ticks = 0; m_cnt = 0; end
      end else if (m_mode == M_RING) begin
        if (stop || !arm) begin
          m_mode = M_IDLE; m_cnt = 0;
        end else if (snooze && m_cnt < MAX_SNOOZE) begin
          m_mode = M_SNZ; m_ticks = 0; m_cnt++;
        end else if (ena) begin
          m_ticks++;
          if (m_ticks == RING_SECS) begin m_mode = M_IDLE; m_cnt = 0; end
        end
      end else begin
        if (stop || !arm) begin
          m_mode = M_IDLE; m_cnt = 0;
        end else if (ena) begin
          m_ticks++;
          if (m_ticks == SNOOZE_SECS) begin m_mode = M_RING; m_ticks = 0; end
        end
      end
    end
    exp_q.push_back({m_mode == M_RING, m_mode == M_SNZ, m_err, m_apm, m_ahh, m_amm, CW'(m_cnt)});
  endtask

  // One clock: model consumes the same inputs the DUT samples, then compare.
  task automatic tick();
    logic [OW-1:0] e;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("ringing",    ringing,    e[OW-1]);
    check("snoozing",   snoozing,   e[OW-2]);
    check("set_err",    set_err,    e[OW-3]);
    check("alarm_pm",   alarm_pm,   e[OW-4]);
    check("alarm_hh",   alarm_hh,   e[OW-5 -: 8]);
    check("alarm_mm",   alarm_mm,   e[OW-13 -: 8]);
    check("snooze_cnt", 8'(snooze_cnt), 8'(e[CW-1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_time(input logic p, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    pm = p; hh = h; mm = m; ss = s;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; tick(); snooze = 1'b0;
  endtask

  // ---------------- alarm-load vector table ----------------
  typedef struct {
    logic       spm;
    logic [7:0] shh, smm;
    logic       e_err, e_pm;
    logic [7:0] e_hh, e_mm;
  } load_vec_t;
  load_vec_t vecs[9];

  logic [7:0] hh_opts[3]  = '{8'h07, 8'h12, 8'h01};
  logic [7:0] mm_opts[3]  = '{8'h30, 8'h00, 8'h59};
  logic [7:0] ss_opts[2]  = '{8'h00, 8'h01};
  logic [7:0] shh_opts[6] = '{8'h01, 8'h07, 8'h12, 8'h13, 8'h00, 8'h0A};
  logic [7:0] smm_opts[5] = '{8'h30, 8'h59, 8'h60, 8'h00, 8'h5A};

  initial begin
    vecs[0] = '{1'b0, 8'h13, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00};
    vecs[1] = '{1'b0, 8'h07, 8'h60, 1'b1, 1'b0, 8'h12, 8'h00};
    vecs[2] = '{1'b1, 8'h07, 8'h30, 1'b0, 1'b1, 8'h07, 8'h30};
    vecs[3] = '{1'b0, 8'h00, 8'h15, 1'b1, 1'b1, 8'h07, 8'h30};
    vecs[4] = '{1'b0, 8'h0A, 8'h00, 1'b1, 1'b1, 8'h07, 8'h30};
    vecs[5] = '{1'b0, 8'h11, 8'h5A, 1'b1, 1'b1, 8'h07, 8'h30};
    vecs[6] = '{1'b1, 8'h12, 8'h59, 1'b0, 1'b1, 8'h12, 8'h59};
    vecs[7] = '{1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00};
    vecs[8] = '{1'b1, 8'h07, 8'h30, 1'b0, 1'b1, 8'h07, 8'h30};

    reset = 1'b1; ena = 1'b0; arm = 1'b0; set_en = 1'b0; set_pm = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; snooze = 1'b0; stop = 1'b0;
    set_time(1'b0, 8'h01, 8'h00, 8'h00);
    tick(); tick();
    check("rst_alarm_pm", alarm_pm, 1'b0);
    check("rst_alarm_hh", alarm_hh, 8'h12);
    check("rst_alarm_mm", alarm_mm, 8'h00);
    check("rst_ringing", ringing, 1'b0);
    check("rst_snoozing", snoozing, 1'b0);
    check("rst_snooze_cnt", 8'(snooze_cnt), 8'd0);
    check("rst_set_err", set_err, 1'b0);
    reset = 1'b0;
    tick();

    // Alarm loads from the table; set_err must drop the cycle after.
    foreach (vecs[i]) begin
      set_en = 1'b1; set_pm = vecs[i].spm; set_hh = vecs[i].shh; set_mm = vecs[i].smm;
      tick();
      set_en = 1'b0;
      check("vec_set_err", set_err, vecs[i].e_err);
      check("vec_alarm_pm", alarm_pm, vecs[i].e_pm);
      check("vec_alarm_hh", alarm_hh, vecs[i].e_hh);
      check("vec_alarm_mm", alarm_mm, vecs[i].e_mm);
      tick();
      check("vec_err_one_cycle", set_err, 1'b0);
    end

    // Match at 07:30:00 PM, held without re-trigger.
    arm = 1'b1;
    set_time(1'b1, 8'h07, 8'h29, 8'h59); tick();
    check("no_ring_before", ringing, 1'b0);
    set_time(1'b1, 8'h07, 8'h30, 8'h00); tick();
    check("ring_on_match", ringing, 1'b1);
    check("state_ringing", 8'(dbg_state), 8'(ST_RINGING));
    repeat (10) tick();
    check("ring_held", ringing, 1'b1);
    set_time(1'b1, 8'h07, 8'h30, 8'h01);

    // Snooze, re-ring after SNOOZE_SECS ticks, timeout after RING_SECS more.
    pulse_snooze();
    check("snz_state", snoozing, 1'b1);
    check("snz_cnt1", 8'(snooze_cnt), 8'd1);
    ena = 1'b1;
    repeat (SNOOZE_SECS - 1) tick();
    check("snz_not_yet", snoozing, 1'b1);
    tick();
    check("re_ring", ringing, 1'b1);
    check("re_ring_cnt", 8'(snooze_cnt), 8'd1);
    repeat (RING_SECS - 1) tick();
    check("ring_not_yet_out", ringing, 1'b1);
    tick();
    check("ring_timeout", ringing, 1'b0);
    check("timeout_cnt", 8'(snooze_cnt), 8'd0);
    ena = 1'b0;

    // Exhaust snoozes, then stop+snooze together.
    set_time(1'b1, 8'h07, 8'h30, 8'h00); tick();
    set_time(1'b1, 8'h07, 8'h30, 8'h01);
    check("ring_again", ringing, 1'b1);
    for (int k = 1; k <= MAX_SNOOZE; k++) begin
      pulse_snooze();
      check("snz_cnt_k", 8'(snooze_cnt), 8'(k));
      ena = 1'b1;
      repeat (SNOOZE_SECS) tick();
      ena = 1'b0;
      check("snz_back_ring", ringing, 1'b1);
    end
    pulse_snooze();
    check("snz_ignored_ring", ringing, 1'b1);
    check("snz_ignored_snz", snoozing, 1'b0);
    check("snz_ignored_cnt", 8'(snooze_cnt), 8'(MAX_SNOOZE));
    stop = 1'b1; snooze = 1'b1; tick(); stop = 1'b0; snooze = 1'b0;
    check("stop_wins_ring", ringing, 1'b0);
    check("stop_wins_snz", snoozing, 1'b0);
    check("stop_wins_cnt", 8'(snooze_cnt), 8'd0);

    // Reset while snoozing.
    set_time(1'b1, 8'h07, 8'h30, 8'h00); tick();
    set_time(1'b1, 8'h07, 8'h30, 8'h01);
    pulse_snooze();
    check("pre_reset_snz", snoozing, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_snz", snoozing, 1'b0);
    check("mid_rst_ring", ringing, 1'b0);
    check("mid_rst_cnt", 8'(snooze_cnt), 8'd0);
    check("mid_rst_hh", alarm_hh, 8'h12);
    check("mid_rst_pm", alarm_pm, 1'b0);
    tick();

    // set_en and trigger on the same edge: load wins, stays idle.
    set_time(1'b0, 8'h12, 8'h00, 8'h00);
    set_en = 1'b1; set_pm = 1'b1; set_hh = 8'h07; set_mm = 8'h30;
    tick(); set_en = 1'b0;
    check("set_beats_trig", ringing, 1'b0);
    check("set_beats_hh", alarm_hh, 8'h07);
    tick();

    // Dropping arm while ringing.
    set_time(1'b1, 8'h07, 8'h29, 8'h59); tick();
    set_time(1'b1, 8'h07, 8'h30, 8'h00); tick();
    check("arm_ring", ringing, 1'b1);
    arm = 1'b0; tick();
    check("disarm_stop", ringing, 1'b0);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      ena    = ($urandom_range(0, 1) == 1);
      arm    = ($urandom_range(0, 49) != 0);
      snooze = ($urandom_range(0, 19) == 0);
      stop   = ($urandom_range(0, 79) == 0);
      set_en = ($urandom_range(0, 59) == 0);
      set_pm = 1'($urandom_range(0, 1));
      set_hh = shh_opts[$urandom_range(0, 5)];
      set_mm = smm_opts[$urandom_range(0, 4)];
      set_time(1'($urandom_range(0, 1)), hh_opts[$urandom_range(0, 2)],
               mm_opts[$urandom_range(0, 2)], ss_opts[$urandom_range(0, 1)]);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/twelve_hour_alarm.md
Name: twelve_hour_alarm

Overview:
- Downstream consumer of twelve_hour_clk. Takes the live BCD time (pm, hh, mm, ss) and the same one-second ena tick.
- Holds a settable alarm time and raises a ringing output when the time matches.
- Supports snooze with a bounded repeat count and automatic timeout.
- Feeds the buzzer/LED stage and the display.

Parameters:
- RING_SECS, 60, ena ticks ringing lasts before auto-stop
- SNOOZE_SECS, 300, ena ticks spent in snooze before re-ring
- MAX_SNOOZE, 3, snoozes accepted per alarm event

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ena  in  1  one-second tick, same signal that drives twelve_hour_clk
- pm  in  1  current AM/PM from clock
- hh  in  8  current hour, BCD 01..12
- mm  in  8  current minute, BCD 00..59
- ss  in  8  current second, BCD 00..59
- arm  in  1  level; alarm enabled
- set_en  in  1  pulse; load alarm time
- set_pm  in  1  alarm AM/PM
- set_hh  in  8  alarm hour, BCD
- set_mm  in  8  alarm minute, BCD
- snooze  in  1  pulse; request snooze
- stop  in  1  pulse; dismiss alarm
- alarm_pm  out  1  stored alarm AM/PM
- alarm_hh  out  8  stored alarm hour
- alarm_mm  out  8  stored alarm minute
- ringing  out  1  alarm sounding
- snoozing  out  1  in snooze interval
- snooze_cnt  out  clog2(MAX_SNOOZE+1)  snoozes used in current event
- set_err  out  1  one-cycle pulse when a set_en load is rejected

Behaviour:
- Clock and reset interface (fixed): single clock clk; reset is synchronous and active-high. All state changes on the posedge of clk only.
- Reset values: alarm_pm=0, alarm_hh=8'h12, alarm_mm=8'h00 (12:00 AM); ringing=0; snoozing=0; snooze_cnt=0; set_err=0; FSM=IDLE; match_q=0.
- Alarm load:
  - set_en loads set_* on the next edge when set_hh is BCD 01..12 and set_mm is BCD 00..59.
  - Any other value leaves the registers unchanged and pulses set_err for 1 cycle.
  - A valid load in RINGING or SNOOZE forces IDLE and clears snooze_cnt.
- Match detection:
  - match = arm && pm==alarm_pm && hh==alarm_hh && mm==alarm_mm && ss==8'h00.
  - match_q registers match each cycle.
  - A trigger is the rising edge of match (match && !match_q); it fires once per minute-match, independent of ena.
- FSM states: IDLE, RINGING, SNOOZE.
- IDLE:
  - On trigger -> RINGING on the next edge.
  - ring_tmr=RING_SECS-1; snooze_cnt=0.
- RINGING (ringing=1):
  - Priority: stop or !arm > snooze > timeout.
  - stop or arm low -> IDLE.
  - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_tmr=SNOOZE_SECS-1; snooze_cnt+1.
  - snooze with snooze_cnt==MAX_SNOOZE is ignored.
  - Each ena decrements ring_tmr. ena while ring_tmr==0 -> IDLE.
- SNOOZE (snoozing=1):
  - stop or !arm -> IDLE.
  - Each ena decrements snooze_tmr. ena while snooze_tmr==0 -> RINGING with ring_tmr reloaded; snooze_cnt is held.
- Output timing:
  - ringing and snoozing are registered and follow state with 1-cycle latency from the causing edge.
  - ringing first asserts the cycle after the trigger cycle.
- Leaving to IDLE clears snooze_cnt (except via valid set_en, already covered).
- Simultaneous events: stop with snooze -> stop wins; set_en with trigger -> set_en wins, FSM stays IDLE.
- Reset mid-ring or mid-snooze returns everything to reset values in one cycle.

Decomposition:
- Shared package clk_pkg:
  - FSM state enum
  - BCD limit constants (HH_MIN=8'h01, HH_MAX=8'h12, MM_MAX=8'h59)
  - default RING_SECS / SNOOZE_SECS
- One natural sub-module: bcd_time_valid, combinational checker of hh/mm legality, reused later by a time-set block.
- Timers and FSM stay in the top module.

Test Plan:
- Reset, then check outputs -> alarm 12:00 AM, ringing=0, snoozing=0, snooze_cnt=0, set_err=0.
- set_en with set_hh=8'h13 or set_mm=8'h60 -> registers unchanged, set_err high exactly 1 cycle. set_en with 07:30 PM -> alarm_hh=8'h07, alarm_mm=8'h30, alarm_pm=1.
- arm=1, alarm 07:30 PM, drive time 07:29:59 PM then 07:30:00 PM -> ringing=1 one cycle after match. Match held for 10 cycles -> no re-trigger.
- While ringing, pulse snooze -> snoozing=1, snooze_cnt=1. After 300 ena ticks -> ringing=1 again. After 60 further ena ticks with no input -> IDLE, ringing=0.
- Snooze 3 times -> 4th snooze pulse ignored, ringing stays 1. Pulse stop and snooze together -> IDLE, snooze_cnt=0.
- Reset asserted during SNOOZE -> next cycle all outputs at reset values. Deassert arm while ringing -> ringing=0 next cycle.
